sub_div_ctrl: RTL
=================

# sub_div_ctrl

Sequencing controller that performs 4-bit unsigned integer division by repeated subtraction, driving one instance of the team's 4-bit `sub` unit (c = a - b, modulo 16) once per cycle. It sits in the calculator datapath alongside the add/sub/mult units. It accepts an operand pair on a start pulse and iterates until the remainder drops below the divisor. It returns quotient, remainder and a divide-by-zero flag with a one-cycle done pulse.

## Interface
- No parameters; all datapath widths are fixed at 4 bits.
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
- start  input  1  request; sampled only in IDLE.
- a  input  4  dividend, unsigned; sampled with start.
- b  input  4  divisor, unsigned; sampled with start.
- quot  output  4  quotient, registered; holds until the next accepted start.
- rem  output  4  remainder, registered; holds until the next accepted start.
- err  output  1  divide-by-zero flag, registered; holds like quot/rem.
- busy  output  1  high in SUB and DONE.
- done  output  1  one-cycle pulse, high only in DONE.

## Operation
- Internal registers: R (running remainder, 4b), D (latched divisor, 4b), Q (count, 4b), state.
- Exactly one `sub` instance, with inputs R and D. Its output is used as the next R.
- Comparison R >= D is a separate unsigned 4-bit compare. The `sub` borrow is not used.
- IDLE:
  - busy=0, done=0.
  - If start=1: R<=a, D<=b, Q<=0, and quot, rem and err are cleared to 0.
  - If b==0: go to DONE with quot<=4'hF, rem<=a, err<=1.
  - Otherwise go to SUB.
- SUB:
  - If R>=D: R<=R-D (from `sub`), Q<=Q+1, stay in SUB.
  - If R<D: quot<=Q, rem<=R, err<=0, go to DONE.
- DONE: done=1, busy=1 for exactly one cycle, then IDLE unconditionally.
- start outside IDLE is ignored, with no queuing. start high in DONE is not accepted; it must still be high in the following IDLE cycle.
- Q never overflows, because Q <= 15 whenever D >= 1. R never wraps, because a subtraction occurs only when R >= D.
- rst_n=0, including mid-operation: state<=IDLE and all registers and outputs <=0 on that edge. A pending operation is discarded, and no done is issued for it.

## Timing
- Reset values: quot=0, rem=0, err=0, busy=0, done=0, state=IDLE.
- Let start be accepted at rising edge k, and let q = floor(a/b).
- For b != 0:
  - busy rises after edge k.
  - Subtractions occur at edges k+1 .. k+q.
  - DONE is entered at edge k+q+1. done is high between edges k+q+1 and k+q+2.
  - Total latency to done is q+1 edges: best case 1 (a<b), worst case 16 (a=15, b=1).
- For b == 0: DONE is entered at edge k, and done is high between edges k and k+1.
- quot, rem and err change only at the start-acceptance edge (cleared) and at the edge entering DONE. They are valid while done=1 and stable afterwards.
- A back-to-back start is accepted at the earliest in the first IDLE cycle after DONE, one cycle after done.

## Test plan
- a=13, b=4, start at edge k -> done high after edge k+4. quot=3, rem=1, err=0. busy high for 5 cycles.
- a=15, b=1 -> done after edge k+16. quot=15, rem=0. Q passes through each value 1..15 with no wrap.
- a=3, b=7 -> done after edge k+1. quot=0, rem=3, err=0. a=0, b=5 -> quot=0, rem=0.
- a=9, b=0 -> done after edge k. err=1, quot=4'hF, rem=9. Then a=8, b=2 -> err=0, quot=4, rem=0.
- Run a=14, b=3 and hold start high with a=2, b=1 throughout busy -> first result quot=4, rem=2 is unaffected. The held start is then accepted in IDLE and gives quot=2, rem=0.
- Run a=15, b=2 and pulse rst_n low at edge k+3 -> at that edge all outputs read 0 and state=IDLE. No done pulse follows. A subsequent a=6, b=3 returns quot=2, rem=0.

Source files
------------

// File: rtl/sub_div_ctrl.sv
// sub_div_ctrl: 4-bit unsigned divider built from repeated subtraction.
// One 4-bit `sub` unit computes the running remainder minus the latched divisor
// once per cycle. Iteration stops when the remainder drops below the divisor.
//
// Ports:
//   clk    in   system clock, rising edge
//   rst_n  in   synchronous active-low reset
//   start  in   request, sampled only in IDLE
//   a      in   [3:0] dividend
//   b      in   [3:0] divisor
//   quot   out  [3:0] quotient (4'hF on divide-by-zero)
//   rem    out  [3:0] remainder (dividend on divide-by-zero)
//   err    out  divide-by-zero flag
//   busy   out  high in SUB and DONE
//   done   out  one-cycle result pulse

// 4-bit subtractor, c = a - b modulo 16.
module sub (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [3:0] c
);
  assign c = a - b;
endmodule

// state  | meaning
// -------+--------------------------------------------------
// S_IDLE | waiting for start; results held
// S_SUB  | one subtraction per cycle while remainder >= divisor
// S_DONE | results valid, done pulse, back to idle next cycle
module sub_div_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [3:0] quot,
  output logic [3:0] rem,
  output logic       err,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SUB  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] r_q, r_d;
  logic [3:0] dv_q, dv_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] quot_q, quot_d;
  logic [3:0] rem_q, rem_d;
  logic       err_q, err_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic [3:0] diff;

  sub u_sub (
    .a (r_q),
    .b (dv_q),
    .c (diff)
  );

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    dv_d    = dv_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          r_d    = a;
          dv_d   = b;
          cnt_d  = 4'd0;
          quot_d = 4'd0;
          rem_d  = 4'd0;
          err_d  = 1'b0;
          if (b == 4'd0) begin
            // Divide-by-zero short-circuits straight to the result.
            quot_d  = 4'hF;
            rem_d   = a;
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_SUB;
          end
        end
      end
      S_SUB: begin
        // Subtract only when it cannot wrap; the sub borrow is not needed.
        if (r_q >= dv_q) begin
          r_d   = diff;
          cnt_d = cnt_q + 4'd1;
        end else begin
          quot_d  = cnt_q;
          rem_d   = r_q;
          err_d   = 1'b0;
          state_d = S_DONE;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Status outputs are registered from the next state so they line up with it.
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      r_q     <= 4'd0;
      dv_q    <= 4'd0;
      cnt_q   <= 4'd0;
      quot_q  <= 4'd0;
      rem_q   <= 4'd0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      dv_q    <= dv_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign quot = quot_q;
  assign rem  = rem_q;
  assign err  = err_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule
